// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: multi-cycle data-memory bus controller that stalls the CPU until each access completes.
// Define DMEM_TIMEOUT_EN to abort REQ after TIMEOUT cycles without bus_ready.
module dmem_bus_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              Fault,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  // Elaboration guard: the timeout counter must be able to hold TIMEOUT.
  if (TIMEOUT >= (64'd1 << TO_W)) begin : g_to_w_too_small
    $error("dmem_bus_ctrl: TO_W too narrow for TIMEOUT");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              fault_q, fault_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              aligned;
  logic              to_hit;

  assign aligned = (ALUResult[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero while idle, so it is clear on every IDLE->REQ entry.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if ((state_q == REQ) && !bus_ready) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_hit = (state_q == REQ) && !bus_ready && (to_cnt_q == TO_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (MemReq) begin
          if (aligned) begin
            state_d     = REQ;
            bus_valid_d = 1'b1;
            bus_we_d    = MemWrite;
            bus_addr_d  = ALUResult;
            bus_wdata_d = WriteData;
          end else begin
            state_d     = ERR;
            fault_d     = 1'b1;
            read_data_d = '0;
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          state_d     = DONE;
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          if (!bus_we_q) begin
            read_data_d = bus_rdata;
          end
        end else if (to_hit) begin
          state_d     = ERR;
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          fault_d     = 1'b1;
          read_data_d = '0;
        end
      end
      // MemReq seen here still belongs to the committing instruction.
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Stall must react in the same cycle MemReq rises, so it is decoded from state.
  assign Stall     = reset & ((state_q == REQ) | ((state_q == IDLE) & MemReq));
  assign ReadData  = read_data_q;
  assign Fault     = fault_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: stimulus queues expected bus transactions,
// a negedge monitor checks the bus and the DONE-cycle result.
module tb_dmem_bus_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Fault;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int          vectors;
  int          miscompares;
  exp_t        exp_q[$];
  int          txn_starts;
  int          valid_cycles;
  int          slave_waits;
  int          slave_cnt;

  dmem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .TO_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave: ready after slave_waits wait states of each transaction.
  always @(posedge clk) begin
    #1;
    if (bus_valid) begin
      bus_ready = (slave_cnt >= slave_waits);
      slave_cnt++;
    end else begin
      bus_ready = 1'b0;
      slave_cnt = 0;
    end
  end

  // Monitor: bus contents against queue head, then result in the following DONE cycle.
  logic done_pend;
  logic prev_valid;
  exp_t cur;
  initial begin
    done_pend  = 1'b0;
    prev_valid = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      done_pend  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (done_pend) begin
        check("done_rdata", ReadData, cur.rd);
        check("done_stall", 32'(Stall), 32'd0);
        check("done_valid", 32'(bus_valid), 32'd0);
        done_pend = 1'b0;
      end
      if (bus_valid) begin
        valid_cycles++;
        if (!prev_valid) txn_starts++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_txn: got addr 0x%08h, expected no transaction", bus_addr);
        end else begin
          check("bus_addr", bus_addr, exp_q[0].addr);
          check("bus_we", 32'(bus_we), 32'(exp_q[0].we));
          check("bus_wdata", bus_wdata, exp_q[0].wdata);
          check("req_stall", 32'(Stall), 32'd1);
          if (bus_ready) begin
            cur       = exp_q.pop_front();
            done_pend = 1'b1;
          end
        end
      end
      prev_valid = bus_valid;
    end
  end

  // One memory instruction; returns just after the commit edge.
  task automatic run_access(input string name, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                            input logic [31:0] exp_rd, input int exp_stall, input bit release_req);
    int stall_cnt;
    stall_cnt   = 0;
    slave_waits = waits;
    bus_rdata   = rdata;
    if (addr[1:0] == 2'b00) exp_q.push_back('{we, addr, wdata, exp_rd});
    MemReq    = 1'b1;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wdata;
    @(negedge clk);
    while (Stall && stall_cnt < 200) begin
      stall_cnt++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (release_req) MemReq = 1'b0;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    MemReq = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int s0, v0, st_cnt;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    txn_starts   = 0;
    valid_cycles = 0;
    slave_waits  = 0;
    slave_cnt    = 0;
    bus_ready    = 1'b0;
    bus_rdata    = '0;
    reset        = 1'b0;
    MemReq       = 1'b1;
    MemWrite     = 1'b0;
    ALUResult    = 32'h0000_0100;
    WriteData    = '0;
    #12;
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    MemReq = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle load
    v0 = valid_cycles;
    run_access("t1_load", 1'b0, 32'h0000_0100, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 2, 1'b1);
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // Store with 3 wait states; load data on the bus must not be captured
    v0 = valid_cycles;
    run_access("t2_store", 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 32'h1234_5678, 5, 1'b1);
    check("t2_valid_cycles", 32'(valid_cycles - v0), 32'd4);
    check("t2_rdata_kept", ReadData, 32'h1234_5678);

    // Misaligned load
    s0 = txn_starts;
    run_access("t3_misalign", 1'b0, 32'h0000_0102, 32'h0, 0, 32'h7777_7777, 32'h0, 1, 1'b1);
    check("t3_no_txn", 32'(txn_starts - s0), 32'd0);
    check("t3_fault", 32'(Fault), 32'd1);
    check("t3_rdata_zero", ReadData, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_fault_sticky", 32'(Fault), 32'd1);

    // Back-to-back loads with MemReq held high
    s0 = txn_starts;
    run_access("t4_load_a", 1'b0, 32'h0000_0010, 32'h0, 1, 32'hA5A5_0010, 32'hA5A5_0010, 3, 1'b0);
    run_access("t4_load_b", 1'b0, 32'h0000_0014, 32'h0, 0, 32'h5A5A_0014, 32'h5A5A_0014, 2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t4_txn_count", 32'(txn_starts - s0), 32'd2);

    // Asynchronous reset in the middle of REQ
    exp_q.push_back('{1'b0, 32'h0000_0020, 32'h0, 32'h0});
    slave_waits = 1000;
    MemReq      = 1'b1;
    MemWrite    = 1'b0;
    ALUResult   = 32'h0000_0020;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus_valid), 32'd0);
    check("t5_async_rdata", ReadData, 32'd0);
    check("t5_async_stall", 32'(Stall), 32'd0);
    exp_q.delete();
    MemReq = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t5_fault_cleared", 32'(Fault), 32'd0);
    check("t5_idle_valid", 32'(bus_valid), 32'd0);
    @(posedge clk);
    #1;
    run_access("t5_after", 1'b0, 32'h0000_0024, 32'h0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 3, 1'b1);

    // Slave never ready
`ifdef DMEM_TIMEOUT_EN
    run_access("t6_timeout", 1'b0, 32'h0000_0040, 32'h0, 100000, 32'h1111_1111, 32'h0, 17, 1'b1);
    check("t6_fault", 32'(Fault), 32'd1);
    check("t6_rdata_zero", ReadData, 32'd0);
    check("t6_valid", 32'(bus_valid), 32'd0);
    exp_q.delete();
`else
    exp_q.push_back('{1'b0, 32'h0000_0040, 32'h0, 32'h0});
    slave_waits = 100000;
    MemReq      = 1'b1;
    MemWrite    = 1'b0;
    ALUResult   = 32'h0000_0040;
    st_cnt      = 0;
    repeat (120) begin
      @(negedge clk);
      if (Stall) st_cnt++;
    end
    check("t6_stall_held", 32'(st_cnt), 32'd120);
    check("t6_no_fault", 32'(Fault), 32'd0);
    check("t6_valid_held", 32'(bus_valid), 32'd1);
    apply_reset();
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got no completion, expected finish before 100000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
